// File: rtl/debounce_sync.sv
// debounce_sync: two-flop synchronizer plus stability-qualified debouncer with rise/fall pulses.
// Optional saturating transition counter (evt_cnt/evt_clr) enabled by `define DEBOUNCE_EVT_CNT_EN.
module debounce_sync #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 16,
   parameter bit RESET_LEVEL     = 1'b0,
   parameter int EVT_W           = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din,
   input  logic             enable,
   output logic             y,
   output logic             rise,
   output logic             fall,
   output logic             busy
`ifdef DEBOUNCE_EVT_CNT_EN
   ,
   output logic [EVT_W-1:0] evt_cnt,
   input  logic             evt_clr
`endif
);
   typedef enum logic {STABLE, PEND} state_t;

   if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (2 ** CNT_W) - 1 || EVT_W < 1) begin : g_bad_param
      $error("debounce_sync: DEBOUNCE_CYCLES out of range for CNT_W");
   end

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sync1_q, sync1_d, sync2_q, sync2_d;
   logic             y_q, y_d, rise_q, rise_d, fall_q, fall_d;
   logic             s;

   assign s    = sync2_q;
   assign y    = y_q;
   assign rise = rise_q;
   assign fall = fall_q;
   assign busy = (state_q == PEND);

   // enable low forces STABLE with a cleared count, overriding every transition below
   always_comb begin
      sync1_d = din;
      sync2_d = sync1_q;
      state_d = STABLE;
      cnt_d   = '0;
      y_d     = y_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (enable && s != y_q) begin
         if (state_q == STABLE) begin
            state_d = PEND;
            cnt_d   = CNT_W'(1);
         end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
            y_d    = s;
            rise_d = s;
            fall_d = ~s;
         end else begin
            state_d = PEND;
            cnt_d   = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= RESET_LEVEL;
         sync2_q <= RESET_LEVEL;
         y_q     <= RESET_LEVEL;
         state_q <= STABLE;
         cnt_q   <= '0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         y_q     <= y_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

`ifdef DEBOUNCE_EVT_CNT_EN
   logic [EVT_W-1:0] evt_q, evt_d;

   assign evt_cnt = evt_q;

   always_comb begin
      evt_d = evt_clr ? '0 : ((rise_q | fall_q) && evt_q != '1) ? evt_q + 1'b1 : evt_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         evt_q <= '0;
      end else begin
         evt_q <= evt_d;
      end
   end
`endif
endmodule
